// File: rtl/fpadd_arbiter.sv
// Two-requester arbiter sharing one 2-cycle hex-float adder; one operation in flight.
// Define FPADD_ARB_RR_EN for round-robin contention; fixed req0 priority otherwise.
module fpadd_arbiter #(
  parameter int unsigned ADD_LAT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] fpa_dataa,
  output logic [31:0] fpa_datab,
  output logic        fpa_add_sub,
  input  logic [31:0] fpa_result,
  output logic        busy,
  output logic        grant_id
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                grant_q, grant_d;
  logic [DATA_W-1:0]   dataa_q, dataa_d;
  logic [DATA_W-1:0]   datab_q, datab_d;
  logic                add_sub_q, add_sub_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                sel;
  logic                accept;
  logic                rsp_ack;

  // Arbitration: a lone valid always wins; contention resolved by priority or pointer
`ifdef FPADD_ARB_RR_EN
  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    sel = !req0_valid;
    if (req0_valid && req1_valid) sel = rr_ptr_q;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = !sel;
  end

  always_ff @(posedge clock) begin
    if (reset) rr_ptr_q <= 1'b0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    sel = !req0_valid;
  end
`endif

  assign accept     = (state_q == ST_IDLE) && (req0_valid || req1_valid);
  assign req0_ready = (state_q == ST_IDLE) && req0_valid && !sel;
  assign req1_ready = (state_q == ST_IDLE) && req1_valid && sel;
  assign rsp_ack    = grant_q ? rsp1_ready : rsp0_ready;

  // Next-state: latch operands on accept, count core latency, hold result until consumed
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    dataa_d    = dataa_q;
    datab_d    = datab_q;
    add_sub_d  = add_sub_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          grant_d   = sel;
          dataa_d   = sel ? req1_a   : req0_a;
          datab_d   = sel ? req1_b   : req0_b;
          add_sub_d = sel ? req1_sub : req0_sub;
          cnt_d     = CNT_W'(ADD_LAT);
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rsp_data_d = fpa_result;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      grant_q    <= 1'b0;
      dataa_q    <= '0;
      datab_q    <= '0;
      add_sub_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      dataa_q    <= dataa_d;
      datab_q    <= datab_d;
      add_sub_q  <= add_sub_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign rsp0_valid  = (state_q == ST_RESP) && !grant_q;
  assign rsp1_valid  = (state_q == ST_RESP) && grant_q;
  assign rsp_data    = rsp_data_q;
  assign fpa_dataa   = dataa_q;
  assign fpa_datab   = datab_q;
  assign fpa_add_sub = add_sub_q;
  assign busy        = (state_q != ST_IDLE);
  assign grant_id    = grant_q;

endmodule

// File: doc/fpadd_arbiter.md
# fpadd_arbiter

Shares one hex-float adder (sign, 7-bit base-16 exponent, 24-bit fraction; 2-cycle register-in/register-out core) between two requesters. Each requester uses a valid/ready operand handshake and a valid/ready result handshake. The block holds adder inputs stable for the whole operation, counts out the fixed core latency, and routes the captured sum back to the requester that issued it. It sits between the datapath sequencers and the single adder instance.

## Interface
- ADD_LAT, 3: edges from operand acceptance to result capture; legal range 1..15. 3 matches the current core.
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- req0_valid / req1_valid  in  1  operand request
- req0_ready / req1_ready  out  1  operand accepted when valid&&ready
- req0_a, req0_b / req1_a, req1_b  in  32  operands
- req0_sub / req1_sub  in  1  add_sub select, passed through
- rsp0_valid / rsp1_valid  out  1  result available
- rsp0_ready / rsp1_ready  in  1  result consumed when valid&&ready
- rsp_data  out  32  captured result, shared by both response channels
- fpa_dataa, fpa_datab  out  32  to adder dataa/datab
- fpa_add_sub  out  1  to adder add_sub
- fpa_result  in  32  from adder result
- busy  out  1  high in any state other than IDLE
- grant_id  out  1  requester of the current or last operation

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - reqN_ready is combinational: state==IDLE && arbiter selects N. At most one ready is high.
  - On accept: latch a/b/sub into fpa_* registers, set grant_id, load cnt=ADD_LAT, go to WAIT.
- WAIT:
  - fpa_* stay frozen.
  - cnt decrements each edge. On the edge where cnt==1, capture fpa_result into rsp_data and go to RESP.
- RESP:
  - rsp{grant_id}_valid is high; the other rsp valid stays 0.
  - rsp_data is stable until the handshake.
  - On valid&&ready, go to IDLE.
  - rsp_ready from the non-granted requester is ignored.
- Requests arriving outside IDLE are not accepted. Requesters must hold valid and operands until accepted.
- Arbitration: only one valid wins. If both are valid, the winner depends on the configuration below.
- One operation in flight at a time; no queuing.
- Reset values: state IDLE, all ready/valid 0, rsp_data 0, fpa_dataa/fpa_datab/fpa_add_sub 0, cnt 0, grant_id 0, round-robin pointer = req0 preferred, busy 0.
- Reset asserted mid-operation aborts it. No response is produced. The adder's in-flight output is discarded because capture only happens in WAIT.

## Timing
- Accept at edge T: fpa_* valid after T; adder registers them at T+1 and produces its output at T+2.
- Capture at edge T+ADD_LAT. rsp_valid is high from T+ADD_LAT.
- Response handshake at edge R: IDLE after R. Earliest next accept at R+1.
- Minimum issue-to-issue interval: ADD_LAT+2 cycles, with rsp_ready held high.
- With rsp_ready held low, RESP holds indefinitely and both req_ready stay 0.
- busy is high from T+1 through R inclusive.

## Configuration
- FPADD_ARB_RR_EN defined: round-robin.
  - When both requesters are valid in IDLE, grant the one not granted last.
  - The pointer updates only on accept.
  - After reset, req0 wins the first contention.
- Undefined: fixed priority. req0 always wins contention, and req1 is served only when req0_valid=0 in IDLE.

## Test plan
- Single op, ADD_LAT=3, real adder: req0 a=0x41100000, b=0x41200000, rsp0_ready=1 -> accept at T, rsp0_valid at T+3, rsp_data=0x41300000, rsp1_valid never asserts.
- Contention, RR_EN defined: both valid continuously with distinct operands -> grants alternate 0,1,0,1. Each result appears only on the matching rsp channel. Issue interval is 5 cycles.
- Contention, RR_EN undefined: both valid for 3 ops -> all three are granted to req0; req1 is accepted only after req0_valid drops.
- Backpressure: rsp0_ready=0 for 10 cycles after rsp0_valid -> rsp_data stable, req1_ready=0, busy=1 throughout. rsp0_ready=1 -> IDLE next cycle, and a pending req1 is accepted one cycle later.
- Operand hold: change req0_a after accept during WAIT -> fpa_dataa unchanged, and the result reflects the originally accepted operands.
- Reset in WAIT at T+1 -> next edge all outputs at reset values, no rsp_valid ever for the aborted op, and a new request is accepted the cycle after reset deasserts.
